// File: rtl/nes_apu_pulse_bank_if.sv
// Register write port of the pulse bank: one write strobe with address and data.
// The pin decoder drives the master side and the APU bank samples the slave side.
interface nes_apu_pulse_bank_if #(
   parameter int ADDR_W = 4
) ();
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/nes_apu_pulse_bank.sv
// Bank of NUM_CH NES-style pulse channels. The channels share one register write port,
// one timer-tick divider and one frame (length-counter) divider. Their outputs feed a
// saturating mixer.
// The optional delta-sigma 1-bit output is built only when NES_APU_PWM_EN is defined.
// Without that macro, pwm_o is tied low.
module nes_apu_pulse_bank #(
   parameter int NUM_CH    = 2,
   parameter int CLK_DIV   = 2,
   parameter int FRAME_DIV = 16,
   parameter int OUT_W     = 5,
   parameter int ADDR_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   nes_apu_pulse_bank_if.slave wr_if,
   output logic [NUM_CH-1:0]   status_o,
   output logic [OUT_W-1:0]    mix_o,
   output logic                pwm_o
);
   localparam int CDIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int FDIV_W = $clog2(FRAME_DIV);
   localparam int CH_W   = ADDR_W - 2;
   // The sum of up to four 4-bit channel outputs fits in 6 bits; keep a margin above OUT_W.
   localparam int SUM_W  = (OUT_W > 6) ? OUT_W + 1 : 7;

   logic [CDIV_W-1:0] cdiv_q;
   logic [FDIV_W-1:0] fdiv_q;
   logic              timer_tick;
   logic              frame_tick;

   assign timer_tick = (cdiv_q == CDIV_W'(CLK_DIV - 1));
   assign frame_tick = (fdiv_q == FDIV_W'(FRAME_DIV - 1));

   // Free-running tick dividers, restarted only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cdiv_q <= '0;
         fdiv_q <= '0;
      end else begin
         cdiv_q <= timer_tick ? '0 : cdiv_q + CDIV_W'(1);
         fdiv_q <= frame_tick ? '0 : fdiv_q + FDIV_W'(1);
      end
   end

   // Address decode: upper bits select the channel, low two bits the register.
   // The first address past the last channel is the shared STATUS register.
   logic [CH_W-1:0] wr_ch;
   logic [1:0]      wr_reg;
   logic            status_wr;

   assign wr_ch     = wr_if.wr_addr[ADDR_W-1:2];
   assign wr_reg    = wr_if.wr_addr[1:0];
   assign status_wr = wr_if.wr_en && (wr_if.wr_addr == ADDR_W'(NUM_CH * 4));

   logic [3:0] ch_out [NUM_CH];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [1:0]  duty_q;
         logic        halt_q;
         logic [3:0]  vol_q;
         logic [10:0] period_q;
         logic [10:0] timer_q;
         logic [2:0]  step_q;
         logic [7:0]  length_q;
         logic        en_q;
         logic        sel;
         logic [7:0]  pat;
         logic        pat_bit;

         assign sel = wr_if.wr_en && (wr_ch == CH_W'(gi));

         // Channel state. Register writes come after the tick updates, so a write
         // overrides a timer step or a length decrement that falls on the same edge.
         always_ff @(posedge clk) begin
            if (rst) begin
               duty_q   <= '0;
               halt_q   <= 1'b0;
               vol_q    <= '0;
               period_q <= '0;
               timer_q  <= '0;
               step_q   <= '0;
               length_q <= '0;
               en_q     <= 1'b0;
            end else begin
               if (timer_tick) begin
                  if (timer_q == '0) begin
                     timer_q <= period_q;
                     step_q  <= step_q + 3'd1;
                  end else begin
                     timer_q <= timer_q - 11'd1;
                  end
               end
               if (frame_tick && !halt_q && (length_q != '0)) begin
                  length_q <= length_q - 8'd1;
               end
               if (sel) begin
                  case (wr_reg)
                     2'd0: begin
                        duty_q <= wr_if.wr_data[7:6];
                        halt_q <= wr_if.wr_data[5];
                        vol_q  <= wr_if.wr_data[3:0];
                     end
                     2'd2: period_q[7:0] <= wr_if.wr_data;
                     2'd3: begin
                        // The timer keeps its current count; only the step restarts.
                        period_q[10:8] <= wr_if.wr_data[2:0];
                        if (en_q) begin
                           length_q <= {3'b000, wr_if.wr_data[7:3]};
                           step_q   <= '0;
                        end
                     end
                     default: ;
                  endcase
               end
               if (status_wr) begin
                  en_q <= wr_if.wr_data[gi];
                  if (!wr_if.wr_data[gi]) begin
                     length_q <= '0;
                  end
               end
            end
         end

         // Duty waveform lookup
         always_comb begin
            case (duty_q)
               2'd0:    pat = 8'b01000000;
               2'd1:    pat = 8'b01100000;
               2'd2:    pat = 8'b01111000;
               default: pat = 8'b10011111;
            endcase
         end

         // Periods below 8 would produce ultrasonic output, so those channels are muted.
         assign pat_bit      = pat[3'd7 - step_q];
         assign ch_out[gi]   = (pat_bit && en_q && (length_q != '0) && (period_q >= 11'd8))
                               ? vol_q : 4'd0;
         assign status_o[gi] = (length_q != '0);
      end
   endgenerate

   logic [SUM_W-1:0] sum;
   logic [OUT_W-1:0] mix_d;
   logic [OUT_W-1:0] mix_q;

   // Add the channel outputs and clamp the sum to the output range
   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum = sum + SUM_W'(ch_out[i]);
      end
      mix_d = (sum > SUM_W'((1 << OUT_W) - 1)) ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
   end

   // Registered mixer output
   always_ff @(posedge clk) begin
      if (rst) begin
         mix_q <= '0;
      end else begin
         mix_q <= mix_d;
      end
   end

   assign mix_o = mix_q;

`ifdef NES_APU_PWM_EN
   logic [OUT_W:0] acc_q;
   logic [OUT_W:0] acc_d;
   logic           pwm_q;

   assign acc_d = {1'b0, acc_q[OUT_W-1:0]} + {1'b0, mix_q};

   // First-order delta-sigma: the carry out of the phase accumulator is the pulse stream
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         pwm_q <= acc_d[OUT_W];
      end
   end

   assign pwm_o = pwm_q;
`else
   assign pwm_o = 1'b0;
`endif

endmodule
